fix_checksum_checker: RTL

- Stream-side stage placed directly upstream of fix_parser_top.
- Watches the raw FIX byte stream, frames each message from "8=" to the closing delimiter after "10=xxx", and computes the FIX checksum (byte sum mod 256).
- Compares the computed checksum against the transmitted three-digit value and flags each message ok or bad.
- Forwards every byte unchanged, one cycle later, so the parser can be fed from data_o.

---
 rtl/fix_checksum_checker.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fix_checksum_checker.sv
// FIX checksum checker: frames each message from '8' to the delimiter after "10=xxx",
// compares the byte-sum-mod-256 with the transmitted digits and forwards the stream 1 cycle late.
module fix_checksum_checker #(
  parameter logic [7:0] DELIM   = 8'h7c,
  parameter int         MAX_LEN = 1024,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_i,
  input  logic             data_valid_i,
  output logic [7:0]       data_o,
  output logic             data_valid_o,
  output logic             msg_start_o,
  output logic             checksum_ok_o,
  output logic             checksum_err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] msg_ok_cnt_o,
  output logic [CNT_W-1:0] msg_err_cnt_o
);
  localparam int               LEN_W        = $clog2(MAX_LEN + 1) + 1;
  localparam logic [LEN_W-1:0] LEN_MAX      = LEN_W'(MAX_LEN);
  localparam logic [1:0]       ERR_MISMATCH = 2'd0;
  localparam logic [1:0]       ERR_FORMAT   = 2'd1;
  localparam logic [1:0]       ERR_OVERLEN  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BODY = 3'd1,
    S_TAG1 = 3'd2,
    S_TAG0 = 3'd3,
    S_CSUM = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       sum_q, sum_d, sum_at_delim_q, sum_at_delim_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [9:0]       digits_q, digits_d;
  logic [1:0]       ndig_q, ndig_d;
  logic             field_start_q, field_start_d;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             start_q, start_d, ok_q, ok_d, err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;
  logic [7:0]       sum_acc_s;
  logic             is_digit_s;

  assign sum_acc_s  = sum_q + data_i;
  assign is_digit_s = (data_i >= 8'h30) && (data_i <= 8'h39);

  // Next-state: framing, tag detection, digit capture and verdict for one accepted byte
  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    sum_at_delim_d = sum_at_delim_q;
    len_d          = len_q;
    digits_d       = digits_q;
    ndig_d         = ndig_q;
    field_start_d  = field_start_q;
    start_d        = 1'b0;
    ok_d           = 1'b0;
    err_d          = 1'b0;
    code_d         = 2'd0;
    if (data_valid_i) begin
      case (state_q)
        S_IDLE: begin
          if (data_i == 8'h38) begin
            state_d       = S_BODY;
            sum_d         = 8'h38;
            len_d         = LEN_W'(1);
            field_start_d = 1'b0;
            start_d       = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BODY, S_TAG1, S_TAG0: begin
          if (len_q == LEN_MAX) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_OVERLEN;
          end else begin
            sum_d         = sum_acc_s;
            len_d         = len_q + LEN_W'(1);
            field_start_d = 1'b0;
            // A failed tag match falls through to ordinary body handling of the same byte
            if ((state_q == S_TAG1) && (data_i == 8'h30)) begin
              state_d = S_TAG0;
            end else if ((state_q == S_TAG0) && (data_i == 8'h3d)) begin
              state_d  = S_CSUM;
              digits_d = 10'd0;
              ndig_d   = 2'd0;
            end else if (data_i == DELIM) begin
              state_d        = S_BODY;
              sum_at_delim_d = sum_acc_s;
              field_start_d  = 1'b1;
            end else if ((data_i == 8'h31) && field_start_q) begin
              state_d = S_TAG1;
            end else begin
              state_d = S_BODY;
            end
          end
        end
        S_CSUM: begin
          if (len_q == LEN_MAX) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_OVERLEN;
          end else begin
            len_d = len_q + LEN_W'(1);
            if (is_digit_s && (ndig_q != 2'd3)) begin
              digits_d = (digits_q * 10'd10) + {6'd0, data_i[3:0]};
              ndig_d   = ndig_q + 2'd1;
            end else if ((data_i == DELIM) && (ndig_q == 2'd3)) begin
              state_d = S_IDLE;
              if (digits_q == {2'b00, sum_at_delim_q}) begin
                ok_d = 1'b1;
              end else begin
                err_d  = 1'b1;
                code_d = ERR_MISMATCH;
              end
            end else begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              code_d  = ERR_FORMAT;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (ok_d) begin
      ok_cnt_d = sat_inc(ok_cnt_q);
    end else begin
      ok_cnt_d = ok_cnt_q;
    end
    if (err_d) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State, pass-through and registered result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      sum_q          <= 8'd0;
      sum_at_delim_q <= 8'd0;
      len_q          <= '0;
      digits_q       <= 10'd0;
      ndig_q         <= 2'd0;
      field_start_q  <= 1'b0;
      data_q         <= 8'd0;
      valid_q        <= 1'b0;
      start_q        <= 1'b0;
      ok_q           <= 1'b0;
      err_q          <= 1'b0;
      code_q         <= 2'd0;
      ok_cnt_q       <= '0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      sum_at_delim_q <= sum_at_delim_d;
      len_q          <= len_d;
      digits_q       <= digits_d;
      ndig_q         <= ndig_d;
      field_start_q  <= field_start_d;
      data_q         <= data_i;
      valid_q        <= data_valid_i;
      start_q        <= start_d;
      ok_q           <= ok_d;
      err_q          <= err_d;
      code_q         <= code_d;
      ok_cnt_q       <= ok_cnt_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign data_o         = data_q;
  assign data_valid_o   = valid_q;
  assign msg_start_o    = start_q;
  assign checksum_ok_o  = ok_q;
  assign checksum_err_o = err_q;
  assign err_code_o     = code_q;
  assign msg_ok_cnt_o   = ok_cnt_q;
  assign msg_err_cnt_o  = err_cnt_q;

endmodule
